// File: rtl/tf_gen_stream_if.sv
// Twiddle-factor output stream: valid/ready handshake carrying a TF vector and its per-lane indices.
interface tf_gen_stream_if #(
   parameter int D_WIDTH = 64,
   parameter int LANES   = 15,
   parameter int CNT_W   = 16
);
   logic                     tf_valid;
   logic                     tf_ready;
   logic [LANES*D_WIDTH-1:0] tf_out;
   logic [LANES*CNT_W-1:0]   idx_out;

   modport master (output tf_valid, tf_out, idx_out, input tf_ready);
   modport slave  (input tf_valid, tf_out, idx_out, output tf_ready);
endinterface

// File: rtl/tf_gen_stream.sv
// Twiddle-factor stream generator: emits LANES base twiddles, then advances each lane by its step
// constant mod q once per accepted vector, for `depth` vectors per run.
module tf_gen_stream #(
   parameter int D_WIDTH    = 64,
   parameter int LANES      = 15,
   parameter int RADIX_K    = 4,
   parameter int RADIX_K2   = 1,
   parameter int LOG_DEGREE = 16,
   parameter int MUL_LAT    = 3,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     base_load,
   input  logic [LANES*D_WIDTH-1:0] base_in,
   input  logic                     const_load,
   input  logic [LANES*D_WIDTH-1:0] const_in,
   input  logic [D_WIDTH-1:0]       modulus,
   input  logic [CNT_W-1:0]         stage_l,
   input  logic                     last_stage,
   input  logic [CNT_W-1:0]         depth,
   input  logic                     start,
   tf_gen_stream_if.master          tf_if,
   output logic                     busy,
   output logic                     done
);
   localparam int VW = LANES * D_WIDTH;
   localparam int IW = LANES * CNT_W;

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_MUL, S_DONE} state_t;

   state_t             state_q;
   logic               tf_valid_q, busy_q, done_q, wb_q, last_q;
   logic [VW-1:0]      tf_out_q, base_q, step_q, work_q;
   logic [IW-1:0]      idx_out_q;
   logic [D_WIDTH-1:0] q_q;
   logic [CNT_W-1:0]   cnt_q, depth_q;

   logic [VW-1:0]      mul_d;
   logic [IW-1:0]      idx_d;
   logic [CNT_W-1:0]   cnt_d;
   logic               fire, last_vec, issue;

   logic [VW-1:0]      res_p [MUL_LAT];
   logic [MUL_LAT-1:0] vld_p;

   function automatic logic [D_WIDTH-1:0] mod_mul(input logic [D_WIDTH-1:0] a,
                                                  input logic [D_WIDTH-1:0] b,
                                                  input logic [D_WIDTH-1:0] q);
      logic [2*D_WIDTH-1:0] prod;
      prod = {{D_WIDTH{1'b0}}, a} * {{D_WIDTH{1'b0}}, b};
      return D_WIDTH'(prod % {{D_WIDTH{1'b0}}, q});
   endfunction

   function automatic int floor_log2(input int v);
      int r;
      r = 0;
      for (int b = 1; b < 31; b++) if (v >= (1 << b)) r = b;
      return r;
   endfunction

   // Lane numbering here is 0-based; the index formula uses the 1-based lane number.
   function automatic logic [CNT_W-1:0] lane_idx(input int lane, input logic [CNT_W-1:0] l,
                                                 input logic last);
      logic [CNT_W-1:0] r;
      if (last) r = (lane == 0) ? CNT_W'(RADIX_K2) : '0;
      else      r = CNT_W'(LOG_DEGREE) - CNT_W'(RADIX_K) * l - CNT_W'(floor_log2(lane + 1));
      return r;
   endfunction

   function automatic logic [VW-1:0] lane_mask(input logic [VW-1:0] v, input logic last);
      logic [VW-1:0] r;
      r = v;
      if (last) for (int i = 1; i < LANES; i++) r[i*D_WIDTH +: D_WIDTH] = '0;
      return r;
   endfunction

   always_comb begin
      mul_d = work_q;
      for (int i = 0; i < LANES; i++)
         if (i == 0 || !last_q)
            mul_d[i*D_WIDTH +: D_WIDTH] = mod_mul(work_q[i*D_WIDTH +: D_WIDTH],
                                                  step_q[i*D_WIDTH +: D_WIDTH], q_q);
      idx_d = '0;
      for (int i = 0; i < LANES; i++) idx_d[i*CNT_W +: CNT_W] = lane_idx(i, stage_l, last_stage);
   end

   assign fire     = (state_q == S_EMIT) && tf_if.tf_ready;
   assign cnt_d    = cnt_q + CNT_W'(1);
   assign last_vec = (cnt_d == depth_q);
   assign issue    = fire && !last_vec;

   // Modmul pipeline: operands captured on the accepting edge, result emerges MUL_LAT cycles later.
   always_ff @(posedge clk) begin
      if (rst) vld_p <= '0;
      else begin
         vld_p[0] <= issue;
         for (int s = 1; s < MUL_LAT; s++) vld_p[s] <= vld_p[s-1];
      end
   end

   always_ff @(posedge clk) begin
      res_p[0] <= mul_d;
      for (int s = 1; s < MUL_LAT; s++) res_p[s] <= res_p[s-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tf_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wb_q       <= 1'b0;
         last_q     <= 1'b0;
         tf_out_q   <= '0;
         idx_out_q  <= '0;
         base_q     <= '0;
         step_q     <= '0;
         work_q     <= '0;
         q_q        <= '0;
         cnt_q      <= '0;
         depth_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  q_q       <= modulus;
                  last_q    <= last_stage;
                  depth_q   <= depth;
                  cnt_q     <= '0;
                  work_q    <= base_q;
                  idx_out_q <= idx_d;
                  busy_q    <= 1'b1;
                  if (depth == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= S_EMIT;
                     tf_valid_q <= 1'b1;
                     tf_out_q   <= lane_mask(base_q, last_stage);
                  end
               end else begin
                  if (base_load)  base_q <= base_in;
                  if (const_load) step_q <= const_in;
               end
            end
            S_EMIT: begin
               if (fire) begin
                  tf_valid_q <= 1'b0;
                  cnt_q      <= cnt_d;
                  if (last_vec) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_MUL;
                  end
               end
            end
            S_MUL: begin
               // Write-back cycle first, then the updated vector is presented on the next edge.
               if (vld_p[MUL_LAT-1]) begin
                  work_q <= res_p[MUL_LAT-1];
                  wb_q   <= 1'b1;
               end
               if (wb_q) begin
                  wb_q       <= 1'b0;
                  state_q    <= S_EMIT;
                  tf_valid_q <= 1'b1;
                  tf_out_q   <= lane_mask(work_q, last_q);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tf_if.tf_valid = tf_valid_q;
   assign tf_if.tf_out   = tf_out_q;
   assign tf_if.idx_out  = idx_out_q;
   assign busy           = busy_q;
   assign done           = done_q;
endmodule

// File: tb/tb_tf_gen_stream.sv
// Directed bench for tf_gen_stream: 3 lanes, 16-bit data, q=17, MUL_LAT=3.
module tb_tf_gen_stream;
   localparam int DW = 16;
   localparam int L  = 3;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst, base_load, const_load, last_stage, start;
   logic [L*DW-1:0] base_in, const_in;
   logic [DW-1:0] modulus;
   logic [CW-1:0] stage_l, depth;
   logic          busy, done;

   int errors = 0;
   int checks = 0;

   logic [L*DW-1:0] got [8];
   logic [L*CW-1:0] got_idx [8];
   int fire_cyc [8];
   int nfire, done_cyc, done_cnt;
   bit stall_bad, timed_out;

   always #5 clk = ~clk;

   tf_gen_stream_if #(.D_WIDTH(DW), .LANES(L), .CNT_W(CW)) tf_if ();

   tf_gen_stream #(.D_WIDTH(DW), .LANES(L), .RADIX_K(2), .RADIX_K2(1), .LOG_DEGREE(8),
                   .MUL_LAT(3), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .base_load(base_load), .base_in(base_in),
      .const_load(const_load), .const_in(const_in), .modulus(modulus),
      .stage_l(stage_l), .last_stage(last_stage), .depth(depth), .start(start),
      .tf_if(tf_if), .busy(busy), .done(done)
   );

   function automatic logic [L*DW-1:0] v3(input int a, input int b, input int c);
      return {DW'(c), DW'(b), DW'(a)};
   endfunction

   function automatic logic [L*CW-1:0] i3(input int a, input int b, input int c);
      return {CW'(c), CW'(b), CW'(a)};
   endfunction

   task automatic load(input logic [L*DW-1:0] b, input logic [L*DW-1:0] c);
      @(negedge clk);
      base_in = b; const_in = c; base_load = 1'b1; const_load = 1'b1;
      @(negedge clk);
      base_load = 1'b0; const_load = 1'b0;
   endtask

   task automatic do_start(input int dep, input int l, input bit last);
      @(negedge clk);
      modulus = 17; stage_l = CW'(l); last_stage = last; depth = CW'(dep); start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Drives tf_ready (optionally stalling one vector) and records accepted vectors and done timing.
   task automatic collect(input int stall_vec, input int stall_len);
      int stalled;
      logic [L*DW-1:0] held;
      stalled = 0; held = '0;
      nfire = 0; done_cyc = -1; done_cnt = 0; stall_bad = 0; timed_out = 1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = n;
         end
         if (tf_if.tf_valid) begin
            if (nfire == stall_vec && stalled < stall_len) begin
               if (stalled == 0) held = tf_if.tf_out;
               else if (tf_if.tf_out !== held) stall_bad = 1;
               tf_if.tf_ready = 1'b0;
               stalled++;
            end else begin
               if (stalled > 0 && nfire == stall_vec && tf_if.tf_out !== held) stall_bad = 1;
               tf_if.tf_ready = 1'b1;
               got[nfire] = tf_if.tf_out;
               got_idx[nfire] = tf_if.idx_out;
               fire_cyc[nfire] = n;
               if (nfire < 7) nfire++;
            end
         end else begin
            if (stalled > 0 && nfire == stall_vec) stall_bad = 1;
            tf_if.tf_ready = 1'b1;
         end
         if (done_cyc >= 0 && n >= done_cyc + 2) begin
            timed_out = 0;
            break;
         end
      end
      tf_if.tf_ready = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (tf_if.tf_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", tf_if.tf_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (tf_if.tf_out !== '0) begin errors++; $display("FAIL reset_tf: got %h want 0", tf_if.tf_out); end
      checks++; if (tf_if.idx_out !== '0) begin errors++; $display("FAIL reset_idx: got %h want 0", tf_if.idx_out); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      load(v3(2, 3, 4), v3(3, 5, 2));
      do_start(3, 0, 0);
      collect(-1, 0);
      checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got no done want done"); end
      checks++; if (nfire !== 3) begin errors++; $display("FAIL basic_count: got %0d want 3", nfire); end
      checks++; if (got[0] !== v3(2, 3, 4)) begin errors++; $display("FAIL basic_v0: got %h want %h", got[0], v3(2, 3, 4)); end
      checks++; if (got[1] !== v3(6, 15, 8)) begin errors++; $display("FAIL basic_v1: got %h want %h", got[1], v3(6, 15, 8)); end
      checks++; if (got[2] !== v3(1, 7, 16)) begin errors++; $display("FAIL basic_v2: got %h want %h", got[2], v3(1, 7, 16)); end
      checks++; if (fire_cyc[1] - fire_cyc[0] !== 5) begin errors++; $display("FAIL basic_gap1: got %0d want 5", fire_cyc[1] - fire_cyc[0]); end
      checks++; if (fire_cyc[2] - fire_cyc[1] !== 5) begin errors++; $display("FAIL basic_gap2: got %0d want 5", fire_cyc[2] - fire_cyc[1]); end
      checks++; if (done_cyc - fire_cyc[2] !== 1) begin errors++; $display("FAIL basic_done_lat: got %0d want 1", done_cyc - fire_cyc[2]); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_len: got %0d want 1", done_cnt); end
      checks++; if (got_idx[0] !== i3(8, 7, 7)) begin errors++; $display("FAIL basic_idx: got %h want %h", got_idx[0], i3(8, 7, 7)); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      do_start(3, 0, 0);
      collect(1, 5);
      checks++; if (nfire !== 3) begin errors++; $display("FAIL bp_count: got %0d want 3", nfire); end
      checks++; if (stall_bad) begin errors++; $display("FAIL bp_stable: got changed want held"); end
      checks++; if (got[1] !== v3(6, 15, 8)) begin errors++; $display("FAIL bp_v1: got %h want %h", got[1], v3(6, 15, 8)); end
      checks++; if (got[2] !== v3(1, 7, 16)) begin errors++; $display("FAIL bp_v2: got %h want %h", got[2], v3(1, 7, 16)); end
      checks++; if (fire_cyc[1] - fire_cyc[0] !== 10) begin errors++; $display("FAIL bp_gap1: got %0d want 10", fire_cyc[1] - fire_cyc[0]); end
      checks++; if (fire_cyc[2] - fire_cyc[1] !== 5) begin errors++; $display("FAIL bp_gap2: got %0d want 5", fire_cyc[2] - fire_cyc[1]); end
      checks++; if (done_cyc - fire_cyc[2] !== 1) begin errors++; $display("FAIL bp_done_lat: got %0d want 1", done_cyc - fire_cyc[2]); end
   endtask

   task automatic test_idx_last_stage();
      do_start(1, 1, 0);
      collect(-1, 0);
      checks++; if (got_idx[0] !== i3(6, 5, 5)) begin errors++; $display("FAIL idx_l1: got %h want %h", got_idx[0], i3(6, 5, 5)); end
      do_start(2, 0, 1);
      collect(-1, 0);
      checks++; if (nfire !== 2) begin errors++; $display("FAIL last_count: got %0d want 2", nfire); end
      checks++; if (got[0] !== v3(2, 0, 0)) begin errors++; $display("FAIL last_v0: got %h want %h", got[0], v3(2, 0, 0)); end
      checks++; if (got[1] !== v3(6, 0, 0)) begin errors++; $display("FAIL last_v1: got %h want %h", got[1], v3(6, 0, 0)); end
      checks++; if (got_idx[0] !== i3(1, 0, 0)) begin errors++; $display("FAIL last_idx: got %h want %h", got_idx[0], i3(1, 0, 0)); end
   endtask

   task automatic test_depth_zero();
      do_start(0, 0, 0);
      @(negedge clk);
      checks++; if (tf_if.tf_valid !== 1'b0) begin errors++; $display("FAIL d0_valid: got %b want 0", tf_if.tf_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL d0_busy: got %b want 1", busy); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL d0_done: got %b want 1", done); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL d0_busy_end: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL d0_done_end: got %b want 0", done); end
      checks++; if (tf_if.tf_valid !== 1'b0) begin errors++; $display("FAIL d0_valid_end: got %b want 0", tf_if.tf_valid); end
   endtask

   task automatic test_reset_mid_run();
      bit stray;
      do_start(3, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (tf_if.tf_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", tf_if.tf_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
      checks++; if (tf_if.tf_out !== '0) begin errors++; $display("FAIL mid_tf: got %h want 0", tf_if.tf_out); end
      checks++; if (tf_if.idx_out !== '0) begin errors++; $display("FAIL mid_idx: got %h want 0", tf_if.idx_out); end
      stray = 0;
      repeat (8) begin
         @(negedge clk);
         if (tf_if.tf_valid || busy) stray = 1;
      end
      checks++; if (stray) begin errors++; $display("FAIL mid_idle: got activity want idle"); end
      do_start(1, 0, 0);
      collect(-1, 0);
      checks++; if (got[0] !== '0) begin errors++; $display("FAIL mid_base_cleared: got %h want 0", got[0]); end
      load(v3(2, 3, 4), v3(3, 5, 2));
      do_start(3, 0, 0);
      collect(-1, 0);
      checks++; if (got[0] !== v3(2, 3, 4)) begin errors++; $display("FAIL mid_restart_v0: got %h want %h", got[0], v3(2, 3, 4)); end
      checks++; if (got[2] !== v3(1, 7, 16)) begin errors++; $display("FAIL mid_restart_v2: got %h want %h", got[2], v3(1, 7, 16)); end
   endtask

   task automatic test_busy_ignore();
      tf_if.tf_ready = 1'b0;
      do_start(3, 0, 0);
      @(negedge clk);
      base_in = v3(9, 9, 9); const_in = v3(1, 1, 1);
      base_load = 1'b1; const_load = 1'b1; start = 1'b1; depth = 5;
      @(negedge clk);
      base_load = 1'b0; const_load = 1'b0; start = 1'b0;
      collect(-1, 0);
      checks++; if (nfire !== 3) begin errors++; $display("FAIL ign_count: got %0d want 3", nfire); end
      checks++; if (got[1] !== v3(6, 15, 8)) begin errors++; $display("FAIL ign_v1: got %h want %h", got[1], v3(6, 15, 8)); end
      checks++; if (got[2] !== v3(1, 7, 16)) begin errors++; $display("FAIL ign_v2: got %h want %h", got[2], v3(1, 7, 16)); end
      do_start(2, 0, 0);
      collect(-1, 0);
      checks++; if (got[0] !== v3(2, 3, 4)) begin errors++; $display("FAIL ign_base_kept: got %h want %h", got[0], v3(2, 3, 4)); end
      checks++; if (got[1] !== v3(6, 15, 8)) begin errors++; $display("FAIL ign_step_kept: got %h want %h", got[1], v3(6, 15, 8)); end
   endtask

   initial begin
      rst = 1'b1; base_load = 1'b0; const_load = 1'b0; start = 1'b0; last_stage = 1'b0;
      base_in = '0; const_in = '0; modulus = 17; stage_l = '0; depth = '0;
      tf_if.tf_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_idx_last_stage();
      test_depth_zero();
      test_reset_mid_run();
      test_busy_ignore();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end
endmodule
